// File: rtl/hamming_encode_engine.sv
//------------------------------------------------------------------------------
// hamming_encode_engine
//   Reads 11-bit messages from byte memory and writes back SECDED codewords.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hamming_encode_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    mem_rd_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          busy,
  output logic          done
);

  localparam int c_idx_w = $clog2(NUM_MSG + 1);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(NUM_MSG - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RLO  = 3'd1,
    S_RHI  = 3'd2,
    S_CAP  = 3'd3,
    S_WLO  = 3'd4,
    S_WHI  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_idx;
  logic [11:1]          r_msg;

  logic [AW-1:0]        w_off;
  logic [AW-1:0]        w_src_lo;
  logic [AW-1:0]        w_dst_lo;
  logic                 w_p8, w_p4, w_p2, w_p1, w_p0;
  logic [15:0]          w_cw;
  logic                 w_unused;

  // High-byte bits [7:3] carry no message data.
  assign w_unused = ^mem_rd_data[7:3];

  assign w_off    = AW'({r_idx, 1'b0});
  assign w_src_lo = AW'(SRC_BASE) + w_off;
  assign w_dst_lo = AW'(DST_BASE) + w_off;

  assign w_p8 = ^r_msg[11:5];
  assign w_p4 = (^r_msg[11:8]) ^ (^r_msg[4:2]);
  assign w_p2 = r_msg[11] ^ r_msg[10] ^ r_msg[7] ^ r_msg[6] ^ r_msg[4] ^ r_msg[3] ^ r_msg[1];
  assign w_p1 = r_msg[11] ^ r_msg[9] ^ r_msg[7] ^ r_msg[5] ^ r_msg[4] ^ r_msg[2] ^ r_msg[1];
  assign w_p0 = (^r_msg[11:1]) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;
  assign w_cw = {r_msg[11:5], w_p8, r_msg[4:2], w_p4, r_msg[1], w_p2, w_p1, w_p0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_msg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE, S_DONE: if (start) r_idx <= '0;
        S_RHI:          r_msg[8:1]  <= mem_rd_data;
        S_CAP:          r_msg[11:9] <= mem_rd_data[2:0];
        S_WHI:          if (r_idx != c_last) r_idx <= r_idx + c_idx_w'(1);
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so they are stable at the edge.
  always_comb begin
    w_state_nxt = r_state;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_RLO;
      end
      S_RLO: begin
        mem_addr    = w_src_lo;
        w_state_nxt = S_RHI;
      end
      S_RHI: begin
        mem_addr    = w_src_lo + AW'(1);
        w_state_nxt = S_CAP;
      end
      S_CAP: w_state_nxt = S_WLO;
      S_WLO: begin
        mem_wr_en   = 1'b1;
        mem_addr    = w_dst_lo;
        mem_wr_data = w_cw[7:0];
        w_state_nxt = S_WHI;
      end
      S_WHI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = w_dst_lo + AW'(1);
        mem_wr_data = w_cw[15:8];
        w_state_nxt = (r_idx == c_last) ? S_DONE : S_RLO;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_state_nxt = S_RLO;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hamming_encode_engine.sv
//------------------------------------------------------------------------------
// tb_hamming_encode_engine
//   Scoreboard bench for the SECDED encoder engine with a byte memory model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hamming_encode_engine;

  localparam int NM  = 15;
  localparam int SRC = 0;
  localparam int DST = 30;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] mem_rd_data;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:255];
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_wd;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] lo; logic [7:0] hi; logic [15:0] cw; } vec_t;

  wr_t  sb_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  hamming_encode_engine #(
    .NUM_MSG (NM),
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .AW      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_rd_data(mem_rd_data),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read byte memory; the bench loads it through its own write port.
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_wd;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every clock advance goes through here so each write strobe meets the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (mem_wr_en) begin
      wr_count++;
      chk("sb_write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wr_data), 32'(e.data));
      end
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  // Classic positional Hamming: parity at power-of-two positions, overall parity at bit 0.
  function automatic logic [15:0] ref_cw(input logic [10:0] m);
    logic [15:0] c;
    int j;
    c = '0; j = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin c[pos] = m[j]; j++; end
    for (int p = 1; p < 16; p = p * 2)
      for (int pos = 1; pos < 16; pos++)
        if ((pos & p) != 0 && pos != p) c[p] = c[p] ^ c[pos];
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic int syndrome(input logic [15:0] c);
    int s;
    s = 0;
    for (int pos = 1; pos < 16; pos++) if (c[pos]) s = s ^ pos;
    return s;
  endfunction

  // 0 = clean, 1 = single (correctable), 2 = double
  function automatic int classify(input logic [15:0] c);
    if (^c) return 1;
    if (syndrome(c) != 0) return 2;
    return 0;
  endfunction

  function automatic logic [10:0] dec_data(input logic [15:0] c);
    logic [15:0] f;
    logic [10:0] m;
    int s, j;
    f = c; s = syndrome(c); j = 0;
    if ((^c) && s != 0) f[s] = ~f[s];
    m = '0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin m[j] = f[pos]; j++; end
    return m;
  endfunction

  function automatic logic [10:0] src_msg(input int i);
    logic [7:0] hi;
    hi = mem[SRC + 2 * i + 1];
    return {hi[2:0], mem[SRC + 2 * i]};
  endfunction

  task automatic push_run(input int n);
    logic [15:0] c;
    for (int i = 0; i < n; i++) begin
      c = ref_cw(src_msg(i));
      sb_q.push_back('{addr: 8'(DST + 2 * i),     data: c[7:0]});
      sb_q.push_back('{addr: 8'(DST + 2 * i + 1), data: c[15:8]});
    end
  endtask

  task automatic run_wait(input int poke_at, output int edges);
    bit bad_busy;
    bad_busy = 1'b0;
    start = 1'b1;
    tick();
    edges = 0;
    while (edges < 400) begin
      start = (edges + 1 == poke_at);
      tick();
      edges++;
      if (done) break;
      if (!busy) bad_busy = 1'b1;
    end
    start = 1'b0;
    chk("busy_during_run", 32'(bad_busy), 32'd0);
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 400) begin
      tick();
      edges++;
      if (done) break;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    int e, base, kind, b1, b2, bad;
    logic [15:0] c;

    vecs[0] = '{lo: 8'h00, hi: 8'h00, cw: 16'h0000};
    vecs[1] = '{lo: 8'hFF, hi: 8'hFF, cw: 16'hFFFF};
    vecs[2] = '{lo: 8'h01, hi: 8'h00, cw: 16'h000F};
    vecs[3] = '{lo: 8'h00, hi: 8'h04, cw: 16'h8117};
    vecs[4] = '{lo: 8'h00, hi: 8'hF8, cw: 16'h0000};

    reset = 1'b0; start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wd = '0;
    tick(); tick();
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_wdata", 32'(mem_wr_data), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // Run 1: table vectors then random messages; a stray start at edge 20.
    for (int i = 0; i < NM; i++) begin
      if (i < 5) begin
        poke(8'(SRC + 2 * i), vecs[i].lo);
        poke(8'(SRC + 2 * i + 1), vecs[i].hi);
      end else begin
        poke(8'(SRC + 2 * i), 8'($urandom_range(0, 255)));
        poke(8'(SRC + 2 * i + 1), 8'($urandom_range(0, 255)));
      end
      poke(8'(DST + 2 * i), 8'hAA);
      poke(8'(DST + 2 * i + 1), 8'hAA);
    end
    push_run(NM);
    base = wr_count;
    run_wait(20, e);
    chk("done_edge", 32'(e), 32'd75);
    chk("write_count", 32'(wr_count - base), 32'd30);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    for (int v = 0; v < 5; v++)
      chk("vec_cw", 32'({mem[DST + 2 * v + 1], mem[DST + 2 * v]}), 32'(vecs[v].cw));
    tick(); tick();
    chk("done_held", 32'(done), 32'd1);
    chk("done_not_busy", 32'(busy), 32'd0);

    // Decoder round trip with injected 0/1/2-bit errors.
    for (int i = 0; i < NM; i++) begin
      c = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
      kind = i % 3;
      b1 = $urandom_range(0, 15);
      b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
      if (kind >= 1) c[b1] = ~c[b1];
      if (kind == 2) c[b2] = ~c[b2];
      chk("dec_class", 32'(classify(c)), 32'(kind));
      if (kind < 2) chk("dec_data", 32'(dec_data(c)), 32'(src_msg(i)));
    end

    // Reset in the middle of message 2.
    for (int i = 0; i < NM; i++) begin
      poke(8'(SRC + 2 * i), 8'($urandom_range(0, 255)));
      poke(8'(SRC + 2 * i + 1), 8'($urandom_range(0, 255)));
      poke(8'(DST + 2 * i), 8'h55);
      poke(8'(DST + 2 * i + 1), 8'h55);
    end
    push_run(2);
    base = wr_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_addr",  32'(mem_addr), 32'd0);
    chk("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("mid_rst_wdata", 32'(mem_wr_data), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_done",  32'(done), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_writes", 32'(wr_count - base), 32'd4);
    chk("mid_rst_sb_drained", 32'(sb_q.size()), 32'd0);
    bad = 0;
    for (int a = DST + 4; a < DST + 2 * NM; a++) if (mem[a] !== 8'h55) bad++;
    chk("dst_untouched", 32'(bad), 32'd0);
    push_run(NM);
    base = wr_count;
    run_wait(0, e);
    chk("rerun_done_edge", 32'(e), 32'd75);
    chk("rerun_writes", 32'(wr_count - base), 32'd30);
    chk("rerun_sb_drained", 32'(sb_q.size()), 32'd0);

    // Start held high: back-to-back runs, done high for one cycle in between.
    push_run(NM);
    push_run(NM);
    base = wr_count;
    start = 1'b1;
    tick();
    wait_done(e);
    chk("hold_done_edge", 32'(e), 32'd75);
    tick();
    chk("hold_done_one_cycle", 32'(done), 32'd0);
    chk("hold_restart_busy", 32'(busy), 32'd1);
    chk("hold_idx_restart", 32'(mem_addr), 32'(SRC));
    start = 1'b0;
    wait_done(e);
    chk("hold_second_done_edge", 32'(e), 32'd75);
    chk("hold_writes", 32'(wr_count - base), 32'd60);
    chk("hold_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
